// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU vector sequencer.
// Vector bundle, FSM states and ALU function codes.
package alu_seq_pkg;

  localparam int DATA_W = 6;
  localparam int FXN_W  = 3;
  localparam int RES_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REPORT
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [FXN_W-1:0]  fxn;
    logic [RES_W-1:0]  exp;
  } vec_t;

  localparam logic [FXN_W-1:0] FXN_LT = 3'b100;

endpackage

// File: rtl/alu_vec_fifo.sv
// Synchronous vector FIFO, DEPTH entries of vec_t.
// Ports: clk, reset, push/din, pop/dout, full, empty.
module alu_vec_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  vec_t din,
  input  logic pop,
  output vec_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB tells full from empty when
  // the index bits are equal.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  vec_t        mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_vector_sequencer.sv
// Queues ALU test vectors, drives the ALU, checks results.
// Ports: vec_* loader in, alu_* to ALU, res_* outcome out, counters.
module alu_vector_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = alu_seq_pkg::DATA_W,
  parameter int FXN_W  = alu_seq_pkg::FXN_W,
  parameter int RES_W  = alu_seq_pkg::RES_W,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DATA_W-1:0] vec_a,
  input  logic [DATA_W-1:0] vec_b,
  input  logic [FXN_W-1:0]  vec_fxn,
  input  logic [RES_W-1:0]  vec_exp,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FXN_W-1:0]  alu_fxn,
  input  logic [RES_W-1:0]  alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_got,
  output logic              res_pass,
  output logic [CNT_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              busy
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state;
  logic [SW-1:0]    settle_cnt;
  logic [RES_W-1:0] exp_q;

  vec_t fifo_din;
  vec_t fifo_dout;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  assign fifo_din = {vec_a, vec_b, vec_fxn, vec_exp};
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  assign vec_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  alu_vec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vec_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      exp_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fxn    <= '0;
      res_valid  <= 1'b0;
      res_got    <= '0;
      res_pass   <= 1'b0;
      res_idx    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a      <= fifo_dout.a;
            alu_b      <= fifo_dout.b;
            alu_fxn    <= fifo_dout.fxn;
            exp_q      <= fifo_dout.exp;
            settle_cnt <= SW'(SETTLE - 1);
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            res_got   <= alu_result;
            res_valid <= 1'b1;
            state     <= ST_REPORT;
            if (alu_result == exp_q) begin
              res_pass <= 1'b1;
              if (pass_cnt != '1) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
              end
            end else begin
              res_pass <= 1'b0;
              if (fail_cnt != '1) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
              end
            end
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_idx   <= res_idx + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
